// File: rtl/coef_ram_arbiter.sv
// Round-robin arbiter sharing one single-port, synchronous-read coefficient RAM
// between the NTT butterfly datapath (port 0) and the load/unload engine (port 1).
module coef_ram_arbiter #(
  parameter int WIDTH     = 24,
  parameter int DEPTH     = 256,
  parameter int MAX_BURST = 16,
  localparam int AW       = $clog2(DEPTH),
  localparam int CW       = $clog2(MAX_BURST + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic             lock0,
  input  logic             lock1,
  input  logic             we0,
  input  logic             we1,
  input  logic [AW-1:0]    addr0,
  input  logic [AW-1:0]    addr1,
  input  logic [WIDTH-1:0] wdata0,
  input  logic [WIDTH-1:0] wdata1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             rvalid0,
  output logic             rvalid1,
  output logic [WIDTH-1:0] rdata0,
  output logic [WIDTH-1:0] rdata1,
  output logic [AW-1:0]    ram_addr,
  output logic             ram_we,
  output logic [WIDTH-1:0] ram_wdata,
  input  logic [WIDTH-1:0] ram_rdata
);

  localparam logic [CW-1:0] CAP = CW'(MAX_BURST);

  logic          last;
  logic          owner_locked;
  logic [CW-1:0] burst_cnt;
  logic [1:0]    rd_pending;

  logic [1:0] req, lock, we, gnt;
  logic       other, gp, any;

  assign req   = {req1, req0};
  assign lock  = {lock1, lock0};
  assign we    = {we1, we0};
  assign other = ~last;
  assign gp    = gnt[1];
  assign any   = |gnt;

  // While locked, the owner is always the last granted port.
  always_comb begin
    // NOTE: assign a default before any branch so no path leaves gnt unassigned
    // (otherwise synthesis infers a latch).
    gnt = 2'b00;
    if (!rst) begin
      if (owner_locked && burst_cnt == CAP && req[other]) gnt[other] = 1'b1;
      else if (owner_locked && req[last])                gnt[last]  = 1'b1;
      else if (&req)                                     gnt[other] = 1'b1;
      else                                               gnt        = req;
    end
  end

  assign gnt0 = gnt[0];
  assign gnt1 = gnt[1];

  always_comb begin
    ram_addr  = '0;
    ram_we    = 1'b0;
    ram_wdata = '0;
    if (any) begin
      ram_addr  = gp ? addr1  : addr0;
      ram_we    = gp ? we1    : we0;
      ram_wdata = gp ? wdata1 : wdata0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last         <= 1'b1;
      owner_locked <= 1'b0;
      burst_cnt    <= '0;
      rd_pending   <= 2'b00;
    end else begin
      rd_pending <= gnt & ~we;
      if (any && lock[gp]) begin
        last         <= gp;
        owner_locked <= 1'b1;
        // Count saturates at the cap so the yield condition stays armed.
        if (owner_locked && last == gp)
          burst_cnt <= (burst_cnt == CAP) ? burst_cnt : CW'(burst_cnt + 1'b1);
        else
          burst_cnt <= CW'(1);
      end else begin
        if (any) last <= gp;
        owner_locked <= 1'b0;
        burst_cnt    <= '0;
      end
    end
  end

  assign rvalid0 = rd_pending[0];
  assign rvalid1 = rd_pending[1];
  assign rdata0  = rd_pending[0] ? ram_rdata : '0;
  assign rdata1  = rd_pending[1] ? ram_rdata : '0;

endmodule

// File: doc/coef_ram_arbiter.md
# coef_ram_arbiter

Two-port round-robin arbiter that shares one single-port, synchronous-read coefficient RAM (the `sio_ram` style: write and registered read on the same address each clock, read returns old data) between two requesters. Port 0 is the NTT butterfly datapath; port 1 is the load/unload engine. Supports locked bursts with a starvation cap, and routes returned read data to the requester that issued the read.

## Interface
- `WIDTH`, 24: coefficient/data width.
- `DEPTH`, 256: RAM words; `AW = $clog2(DEPTH)`.
- `MAX_BURST`, 16: maximum consecutive locked grants before a forced yield; ≥ 2.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `req0` / `req1` in 1: access request.
- `lock0` / `lock1` in 1: keep the grant on the next cycle while `req` stays high.
- `we0` / `we1` in 1: 1 = write, 0 = read.
- `addr0` / `addr1` in AW: word address.
- `wdata0` / `wdata1` in WIDTH: write data.
- `gnt0` / `gnt1` out 1: grant. Combinational. The access happens in a cycle where both `req` and `gnt` are high.
- `rvalid0` / `rvalid1` out 1: read data valid. Registered.
- `rdata0` / `rdata1` out WIDTH: read data. Equals `ram_rdata` when the matching `rvalid` is high, otherwise 0.
- `ram_addr` out AW, `ram_we` out 1, `ram_wdata` out WIDTH: RAM command. Combinational.
- `ram_rdata` in WIDTH: RAM read data, valid one clock after the address.

## Operation
- **State**
  - `last`: index of the most recently granted port.
  - `owner_locked` (1 b): a locked burst is in progress.
  - `burst_cnt` (`$clog2(MAX_BURST+1)` b).
  - `rd_pending[1:0]`: registered read tags.
- **Grant selection** (at most one grant per cycle):
  - **Locked burst** (`owner_locked` = 1): the owner is granted if its `req` = 1. Exception: `burst_cnt == MAX_BURST` and the other port's `req` = 1; then the other port is granted (forced yield).
  - **Otherwise:**
    - Only one port requesting: that port is granted.
    - Both requesting: the port ≠ `last` is granted.
    - Neither requesting: no grant.
- **State update on a grant to port p:**
  - `last` ← p.
  - If `lock_p` = 1:
    - `owner_locked` ← 1.
    - `burst_cnt` ← (p was already the locked owner) ? `burst_cnt` + 1 : 1.
  - Else: `owner_locked` ← 0, `burst_cnt` ← 0.
- **Burst termination:** a cycle with no grant, or the owner dropping `req`, clears `owner_locked` and `burst_cnt`.
- **Forced yield:** clears `owner_locked`. The yielding port then competes normally via round-robin.
- **RAM command:**
  - Granted port's `addr`/`we`/`wdata` are muxed to the RAM.
  - With no grant: `ram_we` = 0, `ram_addr` = 0, `ram_wdata` = 0.
- **Read return:** a granted read (`we` = 0) sets `rd_pending[p]` for the next cycle, which drives `rvalid_p`. Writes never produce `rvalid`.
- **Same-address write then read:** the RAM returns old data on a same-cycle read/write. Because grants are exclusive, a write at cycle N followed by a read of the same address at cycle N+1 returns the new value.

## Timing
- **Reset values:**
  - While `rst` is high, `gnt0`/`gnt1` are forced to 0 and `ram_we` to 0.
  - Registers reset to `last` = 1, `owner_locked` = 0, `burst_cnt` = 0, `rd_pending` = 0.
  - So `rvalid*` = 0, `rdata*` = 0, `ram_addr` = 0, `ram_wdata` = 0.
  - Port 0 wins the first conflict after reset.
- **Latency:**
  - Grant: 0 cycles (same cycle as `req`).
  - Read data: `rvalid_p` in cycle N+1 for a read granted in cycle N.
  - Back-to-back reads give `rvalid` every cycle.
- **Reset mid-burst or mid-read:** the pending `rvalid` is dropped (never emitted), the burst is lost, and arbitration restarts from the reset state.
- **Simultaneous events:**
  - Owner drops `req` while the other port requests: the other port is granted in the same cycle.
  - Both ports asserting `lock`: round-robin decides the first winner; the lock only applies to the winner.
- **Fairness:** with both ports continuously requesting, a locked port holds at most `MAX_BURST` consecutive grants; an unlocked port alternates every cycle.

## Test plan
- **Reset/idle:** assert `rst` async mid-cycle with `req0` = 1.
  - Required: `gnt0` = 0 immediately, `rvalid*` = 0, `ram_we` = 0.
  - After release with `req0` = 1: `gnt0` = 1 in the same cycle.
- **Conflict round-robin:** `req0` = `req1` = 1, no lock, reads to addresses 3 and 7 for 4 cycles.
  - Required: grants 0,1,0,1; `ram_addr` 3,7,3,7; `rvalid0`/`rvalid1` alternate one cycle later.
- **Write-then-read:** port 1 writes 0x00ABC to address 5, then reads address 5 in the next cycle.
  - Required: `rvalid1` = 1 with `rdata1` = 0x00ABC two cycles after the write; `rdata0` = 0 throughout.
- **Locked burst cap:** `MAX_BURST` = 4; port 0 holds `lock0` = 1 and `req0` = 1 with `req1` = 1 throughout.
  - Required: `gnt0` for 4 cycles, `gnt1` on the 5th, then `gnt0` resumes.
- **Owner release:** port 1 is locked and granted, drops `req1` while `req0` = 1.
  - Required: `gnt0` = 1 the same cycle; `burst_cnt` is cleared.
- **Reset during read:** a read is granted at cycle N and `rst` is asserted before edge N+1.
  - Required: `rvalid` never asserts for that read.
